// File: rtl/dispatch_scheduler.sv
// In-order issue queue feeding the ALU, LSU and MULDIV ports with MULDIV occupancy tracking.
// Optional DISPATCH_PERF_EN builds a saturating head-stall cycle counter on stall_cnt_o.
module dispatch_scheduler #(
    parameter int DEPTH      = 4,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic [3:0]  class_i,
    output logic        inst_ready_o,
    input  logic        flush_i,
    output logic        alu_valid_o,
    output logic [31:0] alu_inst_o,
    input  logic        alu_ready_i,
    output logic        lsu_valid_o,
    output logic [31:0] lsu_inst_o,
    input  logic        lsu_ready_i,
    output logic        muldiv_valid_o,
    output logic [31:0] muldiv_inst_o,
    input  logic        muldiv_ready_i,
    output logic        illegal_o,
    output logic [31:0] stall_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MULDIV_LAT + 1);

    typedef enum logic [1:0] {
        P_ALU = 2'd0,
        P_LSU = 2'd1,
        P_MUL = 2'd2
    } port_e;

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   inst_d [DEPTH];
    port_e         port_q [DEPTH];
    port_e         port_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] busy_q, busy_d;
    logic          illegal_q, illegal_d;

    logic          legal;
    logic          offer;
    logic          enq;
    logic          not_empty;
    logic          issue;
    logic          mul_fire;
    port_e         head_port;
    port_e         new_port;
    logic [31:0]   head_inst;

    assign legal     = $onehot(class_i);
    assign not_empty = (count_q != '0);
    assign head_port = port_q[rd_q];
    assign head_inst = inst_q[rd_q];

    assign inst_ready_o = (count_q != CW'(DEPTH));
    assign offer        = inst_valid_i && inst_ready_o;
    assign enq          = offer && legal && !flush_i;

    assign alu_valid_o    = not_empty && (head_port == P_ALU);
    assign lsu_valid_o    = not_empty && (head_port == P_LSU);
    assign muldiv_valid_o = not_empty && (head_port == P_MUL)
                            && (busy_q == '0);

    assign alu_inst_o    = head_inst;
    assign lsu_inst_o    = head_inst;
    assign muldiv_inst_o = head_inst;
    assign illegal_o     = illegal_q;

    assign mul_fire = muldiv_valid_o && muldiv_ready_i;
    assign issue    = (alu_valid_o && alu_ready_i)
                    || (lsu_valid_o && lsu_ready_i)
                    || mul_fire;

    // Branches share the ALU port with plain ALU ops.
    always_comb begin
        new_port = P_ALU;
        if (class_i[2]) begin
            new_port = P_LSU;
        end else if (class_i[1]) begin
            new_port = P_MUL;
        end
    end

    always_comb begin
        inst_d    = inst_q;
        port_d    = port_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        count_d   = count_q;
        busy_d    = busy_q;
        illegal_d = offer && !legal;

        if (enq) begin
            inst_d[wr_q] = inst_i;
            port_d[wr_q] = new_port;
        end

        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wr_d = wr_q + AW'(1);
            end
            if (issue) begin
                rd_d = rd_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(issue);
        end

        if (mul_fire) begin
            busy_d = BW'(MULDIV_LAT - 1);
        end else if (busy_q != '0) begin
            busy_d = busy_q - BW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                port_q[i] <= P_ALU;
            end
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            inst_q    <= inst_d;
            port_q    <= port_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (not_empty && !issue && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
